// File: rtl/tick_divider_pkg.sv
// Shared types and constants for the programmable tick divider.
package tick_divider_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_CONT    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/tick_divider.sv
// Programmable clock-enable divider: emits a one-cycle tick every N+1 clock
// cycles, toggles a square wave on each tick, and accepts new periods
// through a valid/ready load port.  The new period takes effect at the next
// terminal count, so the tick in progress always keeps the old period.
module tick_divider
    import tick_divider_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] div_value,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             tick,
    output logic             toggle_out,
    output logic             busy,
    output logic [WIDTH-1:0] count
);

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   period_reg, period_next;
    logic [WIDTH-1:0]   pending_reg, pending_next;
    logic               pend_v_reg, pend_v_next;
    logic [WIDTH-1:0]   count_reg, count_next;
    logic               mode_reg, mode_next;
    logic               tick_reg, tick_next;
    logic               toggle_reg, toggle_next;

    logic               load;
    logic               terminal;
    logic [WIDTH-1:0]   reload_value;

    // A single pending slot: while running, one queued period blocks further loads.
    assign div_ready = (state_reg == IDLE) || !pend_v_reg;
    assign load      = div_valid && div_ready;
    assign terminal  = en && (count_reg == '0);

    // A load arriving on the terminal cycle bypasses the pending slot.
    assign reload_value = load       ? div_value   :
                          pend_v_reg ? pending_reg : period_reg;

    // Next-state and datapath decisions; stop overrides everything else.
    always_comb begin
        state_next   = state_reg;
        period_next  = period_reg;
        pending_next = pending_reg;
        pend_v_next  = pend_v_reg;
        count_next   = count_reg;
        mode_next    = mode_reg;
        tick_next    = 1'b0;
        toggle_next  = toggle_reg;

        if (stop) begin
            state_next  = IDLE;
            count_next  = '0;
            pend_v_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load) begin
                        period_next = div_value;
                    end
                    if (start) begin
                        count_next = load ? div_value : period_reg;
                        mode_next  = mode;
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (terminal) begin
                        tick_next   = 1'b1;
                        toggle_next = !toggle_reg;
                        period_next = reload_value;
                        pend_v_next = 1'b0;
                        if (mode_reg == MODE_ONESHOT) begin
                            state_next = IDLE;
                            count_next = '0;
                        end else begin
                            count_next = reload_value;
                        end
                    end else begin
                        if (en) begin
                            count_next = count_reg - WIDTH'(1);
                        end
                        if (load) begin
                            pending_next = div_value;
                            pend_v_next  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    count_next = '0;
                end
            endcase
        end
    end

    // State register with asynchronous clear of every output-visible flop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            period_reg  <= '0;
            pending_reg <= '0;
            pend_v_reg  <= 1'b0;
            count_reg   <= '0;
            mode_reg    <= MODE_CONT;
            tick_reg    <= 1'b0;
            toggle_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            period_reg  <= period_next;
            pending_reg <= pending_next;
            pend_v_reg  <= pend_v_next;
            count_reg   <= count_next;
            mode_reg    <= mode_next;
            tick_reg    <= tick_next;
            toggle_reg  <= toggle_next;
        end
    end

    assign tick       = tick_reg;
    assign toggle_out = toggle_reg;
    assign busy       = (state_reg == RUN);
    assign count      = count_reg;

endmodule
